// File: rtl/stopwatch_core.sv
// stopwatch_core: minutes:seconds stopwatch datapath.
// Counts advance on external one-cycle tick enables. Adjust mode bumps
// either field by a fixed step. A one-cycle button pulse toggles a
// latched pause. The block also drives BCD digits for the display and a
// pulse when the minutes field wraps during normal counting.
module stopwatch_core #(
   parameter int SEC_MOD  = 60,
   parameter int MIN_MOD  = 60,
   parameter int ADJ_STEP = 2,
   parameter int CW       = 7
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          tick_1hz,
   input  logic          tick_adj,
   input  logic          adj,
   input  logic          sel,
   input  logic          pse_pulse,
   output logic [CW-1:0] sec,
   output logic [CW-1:0] min,
   output logic [7:0]    sec_bcd,
   output logic [7:0]    min_bcd,
   output logic          paused,
   output logic          rollover
);

   // Moduli and step are sized to the count width so that every
   // comparison and subtraction below stays CW bits wide.
   localparam logic [CW-1:0] SEC_MOD_C  = CW'(SEC_MOD);
   localparam logic [CW-1:0] MIN_MOD_C  = CW'(MIN_MOD);
   localparam logic [CW-1:0] SEC_LAST   = CW'(SEC_MOD - 1);
   localparam logic [CW-1:0] MIN_LAST   = CW'(MIN_MOD - 1);
   localparam logic [CW-1:0] ADJ_STEP_C = CW'(ADJ_STEP);
   localparam logic [CW-1:0] ONE_C      = CW'(1);

   typedef enum logic [1:0] {
      MODE_RUN,
      MODE_ADJUST,
      MODE_PAUSED
   } mode_e;

   mode_e         mode;
   logic [CW-1:0] sec_q, sec_d;
   logic [CW-1:0] min_q, min_d;
   logic          paused_q, paused_d;
   logic          rollover_q, rollover_d;
   logic [CW-1:0] sec_inc, min_inc;
   logic [CW-1:0] sec_adj_sum, min_adj_sum;

   // Turn a 0..99 count into packed {tens, ones} BCD with a constant divide.
   function automatic logic [7:0] to_bcd(input logic [CW-1:0] value);
      logic [7:0] v8;
      logic [3:0] tens;
      logic [3:0] ones;
      v8   = 8'(value);
      tens = 4'(v8 / 8'd10);
      ones = 4'(v8 % 8'd10);
      return {tens, ones};
   endfunction

   // Pick the active mode; pause outranks adjust, which outranks running.
   always_comb begin
      mode = MODE_RUN;
      if (paused_q) begin
         mode = MODE_PAUSED;
      end else if (adj) begin
         mode = MODE_ADJUST;
      end
   end

   // Work out the next counts, pause state and wrap pulse for this edge.
   always_comb begin
      sec_inc     = sec_q + ONE_C;
      min_inc     = min_q + ONE_C;
      sec_adj_sum = sec_q + ADJ_STEP_C;
      min_adj_sum = min_q + ADJ_STEP_C;
      sec_d       = sec_q;
      min_d       = min_q;
      rollover_d  = 1'b0;
      paused_d    = paused_q ^ pse_pulse;
      case (mode)
         MODE_RUN: begin
            if (tick_1hz) begin
               if (sec_q == SEC_LAST) begin
                  sec_d = '0;
                  if (min_q == MIN_LAST) begin
                     min_d      = '0;
                     rollover_d = 1'b1;
                  end else begin
                     min_d = min_inc;
                  end
               end else begin
                  sec_d = sec_inc;
               end
            end
         end
         MODE_ADJUST: begin
            if (tick_adj) begin
               if (sel) begin
                  sec_d = (sec_adj_sum >= SEC_MOD_C) ? (sec_adj_sum - SEC_MOD_C) : sec_adj_sum;
               end else begin
                  min_d = (min_adj_sum >= MIN_MOD_C) ? (min_adj_sum - MIN_MOD_C) : min_adj_sum;
               end
            end
         end
         default: begin
         end
      endcase
   end

   // Hold the count, pause and wrap-pulse registers; reset clears them at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sec_q      <= '0;
         min_q      <= '0;
         paused_q   <= 1'b0;
         rollover_q <= 1'b0;
      end else begin
         sec_q      <= sec_d;
         min_q      <= min_d;
         paused_q   <= paused_d;
         rollover_q <= rollover_d;
      end
   end

   assign sec      = sec_q;
   assign min      = min_q;
   assign paused   = paused_q;
   assign rollover = rollover_q;
   assign sec_bcd  = to_bcd(sec_q);
   assign min_bcd  = to_bcd(min_q);

endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core: drives two stopwatch_core instances with the same
// inputs. One uses the default 60/60/2 parameters and the other uses
// 10/24/3. Both are checked every cycle against a behavioural model that
// keeps the time as a total count of seconds.
module tb_stopwatch_core;

   localparam int SM_A = 60, MM_A = 60, ST_A = 2, CW_A = 7;
   localparam int SM_B = 10, MM_B = 24, ST_B = 3, CW_B = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tick_1hz = 1'b0, tick_adj = 1'b0, adj = 1'b0, sel = 1'b0, pse_pulse = 1'b0;

   logic [CW_A-1:0] sec_a, min_a;
   logic [CW_B-1:0] sec_b, min_b;
   logic [7:0]      sec_bcd_a, min_bcd_a, sec_bcd_b, min_bcd_b;
   logic            paused_a, paused_b, rollover_a, rollover_b;

   int checks = 0;
   int failures = 0;

   int m_sec[2];
   int m_min[2];
   int m_roll[2];
   int m_paused;

   stopwatch_core #(.SEC_MOD(SM_A), .MIN_MOD(MM_A), .ADJ_STEP(ST_A), .CW(CW_A)) dut_a (
      .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_adj(tick_adj), .adj(adj),
      .sel(sel), .pse_pulse(pse_pulse), .sec(sec_a), .min(min_a), .sec_bcd(sec_bcd_a),
      .min_bcd(min_bcd_a), .paused(paused_a), .rollover(rollover_a));

   stopwatch_core #(.SEC_MOD(SM_B), .MIN_MOD(MM_B), .ADJ_STEP(ST_B), .CW(CW_B)) dut_b (
      .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_adj(tick_adj), .adj(adj),
      .sel(sel), .pse_pulse(pse_pulse), .sec(sec_b), .min(min_b), .sec_bcd(sec_bcd_b),
      .min_bcd(min_bcd_b), .paused(paused_b), .rollover(rollover_b));

   // Free-running clock with a 10-unit period.
   always #5 clk = ~clk;

   function automatic int bcdOf(input int v);
      return (v / 10) * 16 + (v % 10);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                  tag, observed, observed, expected, expected, $time);
      end
   endtask

   task automatic modelReset();
      for (int i = 0; i < 2; i++) begin
         m_sec[i]  = 0;
         m_min[i]  = 0;
         m_roll[i] = 0;
      end
      m_paused = 0;
   endtask

   // Advance one instance of the model by one edge, given the sampled inputs.
   task automatic modelStep(input int i, input int sm, input int mm, input int st,
                            input logic t1, input logic ta, input logic a, input logic s);
      int total;
      m_roll[i] = 0;
      if (m_paused == 0) begin
         if (a) begin
            if (ta) begin
               if (s) m_sec[i] = (m_sec[i] + st) % sm;
               else   m_min[i] = (m_min[i] + st) % mm;
            end
         end else if (t1) begin
            total     = (m_min[i] * sm + m_sec[i] + 1) % (sm * mm);
            m_sec[i]  = total % sm;
            m_min[i]  = total / sm;
            m_roll[i] = (total == 0) ? 1 : 0;
         end
      end
   endtask

   task automatic compareAll();
      checkOutput("a_sec",      32'(sec_a),      32'(m_sec[0]));
      checkOutput("a_min",      32'(min_a),      32'(m_min[0]));
      checkOutput("a_sec_bcd",  32'(sec_bcd_a),  32'(bcdOf(m_sec[0])));
      checkOutput("a_min_bcd",  32'(min_bcd_a),  32'(bcdOf(m_min[0])));
      checkOutput("a_rollover", 32'(rollover_a), 32'(m_roll[0]));
      checkOutput("a_paused",   32'(paused_a),   32'(m_paused));
      checkOutput("b_sec",      32'(sec_b),      32'(m_sec[1]));
      checkOutput("b_min",      32'(min_b),      32'(m_min[1]));
      checkOutput("b_sec_bcd",  32'(sec_bcd_b),  32'(bcdOf(m_sec[1])));
      checkOutput("b_min_bcd",  32'(min_bcd_b),  32'(bcdOf(m_min[1])));
      checkOutput("b_rollover", 32'(rollover_b), 32'(m_roll[1]));
      checkOutput("b_paused",   32'(paused_b),   32'(m_paused));
   endtask

   // Drive one cycle of inputs, step the model across the edge and compare.
   task automatic applyStimulus(input logic t1, input logic ta, input logic a,
                                input logic s, input logic p);
      @(negedge clk);
      tick_1hz  = t1;
      tick_adj  = ta;
      adj       = a;
      sel       = s;
      pse_pulse = p;
      @(posedge clk);
      #1;
      modelStep(0, SM_A, MM_A, ST_A, t1, ta, a, s);
      modelStep(1, SM_B, MM_B, ST_B, t1, ta, a, s);
      if (p) m_paused = 1 - m_paused;
      tick_1hz  = 1'b0;
      tick_adj  = 1'b0;
      pse_pulse = 1'b0;
      compareAll();
   endtask

   task automatic doReset();
      @(negedge clk);
      rst = 1'b1;
      tick_1hz = 1'b0; tick_adj = 1'b0; adj = 1'b0; sel = 1'b0; pse_pulse = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      modelReset();
      #1;
      compareAll();
   endtask

   task automatic runTicks(input int n);
      for (int k = 0; k < n; k++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      modelReset();
      #1;
      checkOutput("rst_sec", 32'(sec_a), 32'd0);
      checkOutput("rst_paused", 32'(paused_a), 32'd0);
      doReset();

      // Run wrap from 59:59: adjust minutes to 58, then 119 run ticks.
      for (int k = 0; k < 29; k++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("preload_min58", 32'(min_a), 32'd58);
      runTicks(119);
      checkOutput("pre_wrap_sec", 32'(sec_a), 32'd59);
      checkOutput("pre_wrap_min", 32'(min_a), 32'd59);
      runTicks(1);
      checkOutput("wrap_sec", 32'(sec_a), 32'd0);
      checkOutput("wrap_min", 32'(min_a), 32'd0);
      checkOutput("wrap_roll", 32'(rollover_a), 32'd1);
      checkOutput("wrap_sec_bcd", 32'(sec_bcd_a), 32'h00);
      checkOutput("wrap_min_bcd", 32'(min_bcd_a), 32'h00);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("wrap_roll_drop", 32'(rollover_a), 32'd0);

      // Adjust minutes from 59 wraps to 1 and leaves seconds alone.
      doReset();
      for (int k = 0; k < 29; k++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      runTicks(61);
      checkOutput("adjmin_pre", 32'(min_a), 32'd59);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("adjmin_min", 32'(min_a), 32'd1);
      checkOutput("adjmin_sec", 32'(sec_a), 32'd1);
      checkOutput("adjmin_roll", 32'(rollover_a), 32'd0);

      // Adjust seconds from 05:58 gives 05:00 with no carry; run tick is ignored.
      doReset();
      runTicks(358);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      checkOutput("adjsec_sec", 32'(sec_a), 32'd0);
      checkOutput("adjsec_min", 32'(min_a), 32'd5);
      checkOutput("adjsec_roll", 32'(rollover_a), 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      checkOutput("adj_ignores_1hz", 32'(sec_a), 32'd0);

      // Pause freezes counts; a pulse coincident with a tick unpauses but drops the tick.
      doReset();
      runTicks(5);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("pause_on", 32'(paused_a), 32'd1);
      runTicks(3);
      checkOutput("pause_frozen", 32'(sec_a), 32'd5);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("pause_off", 32'(paused_a), 32'd0);
      checkOutput("pause_tick_dropped", 32'(sec_a), 32'd5);
      runTicks(1);
      checkOutput("resume_tick", 32'(sec_a), 32'd6);

      // Variant instance: 23:09 wraps to 00:00, and adjust seconds from 8 gives 1.
      doReset();
      runTicks(239);
      checkOutput("b_pre_sec", 32'(sec_b), 32'd9);
      checkOutput("b_pre_min_bcd", 32'(min_bcd_b), 32'h23);
      runTicks(1);
      checkOutput("b_wrap_sec", 32'(sec_b), 32'd0);
      checkOutput("b_wrap_min", 32'(min_b), 32'd0);
      checkOutput("b_wrap_roll", 32'(rollover_b), 32'd1);
      doReset();
      runTicks(8);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      checkOutput("b_adjsec", 32'(sec_b), 32'd1);

      // Asynchronous reset at 12:37 clears outputs with no clock edge.
      doReset();
      runTicks(757);
      checkOutput("mid_sec", 32'(sec_a), 32'd37);
      checkOutput("mid_min", 32'(min_a), 32'd12);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("async_sec", 32'(sec_a), 32'd0);
      checkOutput("async_min", 32'(min_a), 32'd0);
      checkOutput("async_sec_bcd", 32'(sec_bcd_a), 32'h00);
      checkOutput("async_min_bcd", 32'(min_bcd_a), 32'h00);
      checkOutput("async_paused", 32'(paused_a), 32'd0);
      modelReset();
      compareAll();
      @(negedge clk);
      rst = 1'b0;

      // Randomized traffic, compared every cycle.
      for (int k = 0; k < 3000; k++) begin
         logic r_t1, r_ta, r_a, r_s, r_p;
         r_t1 = ($urandom % 3) == 0;
         r_ta = ($urandom % 3) == 0;
         r_a  = ($urandom % 4) == 0;
         r_s  = ($urandom % 2) == 0;
         r_p  = ($urandom % 16) == 0;
         applyStimulus(r_t1, r_ta, r_a, r_s, r_p);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
